// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: launches an ap_ctrl_hs / ap_ctrl_chain kernel a commanded number
// of times and streams the start-to-done latency of every invocation.
module ap_ctrl_driver #(
  parameter int CNT_W = 32,
  parameter int LAT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [15:0]      cmd_gap,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [LAT_W-1:0] res_latency,
  output logic [CNT_W-1:0] res_index,
  output logic             busy,
  output logic             done_pulse,
  output logic             err_spurious,
  output logic [2:0]       dbg_state
);
  // Handshakes: a cmd transfers on cmd_valid & cmd_ready, a result on
  // res_valid & res_ready, a launch on ap_start & ap_ready and a completion on
  // ap_done & ap_continue; valid/start/done never drop before their transfer.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_GAP, S_DRAIN, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      gap_q, gap_d;
  logic [15:0]      gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] completed_q, completed_d;
  logic [LAT_W-1:0] cyc_q, cyc_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             pending_q, pending_d;
  logic             res_valid_q, res_valid_d;
  logic [LAT_W-1:0] res_latency_q, res_latency_d;
  logic [CNT_W-1:0] res_index_q, res_index_d;
  logic             err_q, err_d;
  logic [LAT_W-1:0] fifo_mem [DEPTH];

  logic accept, pop, push, issue;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      issued_q      <= '0;
      completed_q   <= '0;
      cyc_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      pending_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_latency_q <= '0;
      res_index_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      issued_q      <= issued_d;
      completed_q   <= completed_d;
      cyc_q         <= cyc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      pending_q     <= pending_d;
      res_valid_q   <= res_valid_d;
      res_latency_q <= res_latency_d;
      res_index_q   <= res_index_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) fifo_mem[wr_ptr_q] <= cyc_q;
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    gap_d         = gap_q;
    gap_cnt_d     = gap_cnt_q;
    issued_d      = issued_q;
    completed_d   = completed_q;
    cyc_d         = cyc_q + LAT_W'(1);
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    pending_d     = pending_q;
    res_valid_d   = res_valid_q;
    res_latency_d = res_latency_q;
    res_index_d   = res_index_q;
    err_d         = err_q;

    ap_continue = !res_valid_q || res_ready;
    accept      = ap_done && ap_continue;
    pop         = accept && (occ_q != '0);
    // Once a timestamp is pushed, ap_start must hold until ap_ready even if the FIFO filled.
    ap_start    = (state_q == S_START) && ((occ_q < OCC_FULL) || pending_q);
    issue       = ap_start && ap_ready;
    push        = ap_start && !pending_q;

    if (ap_start) pending_d = !ap_ready;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    if (accept && (occ_q == '0)) err_d = 1'b1;
    if (res_ready) res_valid_d = 1'b0;
    if (pop) begin
      res_valid_d   = 1'b1;
      res_latency_d = cyc_q - fifo_mem[rd_ptr_q];
      res_index_d   = completed_q;
      completed_d   = completed_q + CNT_W'(1);
    end
    if (issue) issued_d = issued_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          count_d     = cmd_count;
          gap_d       = cmd_gap;
          issued_d    = '0;
          completed_d = '0;
          res_index_d = '0;
          state_d     = (cmd_count == '0) ? S_FIN : S_START;
        end
      end
      S_START: begin
        if (issue) begin
          // A kernel may raise ap_done with its last ap_ready; skip DRAIN then.
          if (issued_d == count_q) begin
            state_d = (completed_d == count_q) ? S_FIN : S_DRAIN;
          end else if (gap_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= 16'd1) state_d = S_START;
        else gap_cnt_d = gap_cnt_q - 16'd1;
      end
      S_DRAIN: begin
        if (completed_d == count_q) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign done_pulse   = (state_q == S_FIN);
  assign res_valid    = res_valid_q;
  assign res_latency  = res_latency_q;
  assign res_index    = res_index_q;
  assign err_spurious = err_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Directed bench for ap_ctrl_driver: a small kernel model answers ap_start with
// programmable ap_ready/ap_done delays; results are checked against hand values.
module tb_ap_ctrl_driver;
  localparam int CNT_W = 8;
  localparam int LAT_W = 4;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [15:0]      cmd_gap = '0;
  logic             ap_start;
  logic             ap_ready = 1'b0;
  logic             ap_done = 1'b0;
  logic             ap_continue;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [LAT_W-1:0] res_latency;
  logic [CNT_W-1:0] res_index;
  logic             busy;
  logic             done_pulse;
  logic             err_spurious;
  logic [2:0]       dbg_state;

  ap_ctrl_driver #(.CNT_W(CNT_W), .LAT_W(LAT_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count), .cmd_gap(cmd_gap),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .res_valid(res_valid), .res_ready(res_ready), .res_latency(res_latency), .res_index(res_index),
    .busy(busy), .done_pulse(done_pulse), .err_spurious(err_spurious), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // kernel model and bookkeeping
  int cyc_n = 0;
  int cyc_m = 0;
  int k_rd = 0;
  int k_dd = 1;
  bit k_pending = 0;
  int k_start = 0;
  bit k_spur = 0;
  int k_start_q[$];
  int k_due_q[$];
  int rr_from = -1;
  int rr_to = -2;
  bit cmd_go = 0;
  int go_count = 0;
  int go_gap = 0;

  logic [CNT_W+LAT_W-1:0] exp_q[$];
  int exp_idx = 0;
  int start_cyc[$];
  int res_lat[$];
  int n_res, n_pulse, pulse_cyc, start_hi_cnt, cont_lo_cnt;
  int cmd_acc_cyc, last_done_cyc, outstanding, max_out;

  function automatic int sc(input int i);
    return (i < start_cyc.size()) ? start_cyc[i] : -1000;
  endfunction

  function automatic int rl(input int i);
    return (i < res_lat.size()) ? res_lat[i] : -1;
  endfunction

  task automatic clear_stats();
    exp_idx = 0;
    start_cyc.delete();
    res_lat.delete();
    n_res = 0; n_pulse = 0; pulse_cyc = -1; start_hi_cnt = 0; cont_lo_cnt = 0;
    cmd_acc_cyc = -1; last_done_cyc = -1; max_out = 0;
  endtask

  task automatic kernel_reset();
    k_pending = 0;
    k_start_q.delete();
    k_due_q.delete();
    exp_q.delete();
    outstanding = 0;
  endtask

  // One clock cycle: drive inputs at negedge, observe outputs 1 time unit later.
  task automatic step();
    logic [CNT_W+LAT_W-1:0] e;
    int s;
    cyc_m = reset ? 0 : (cyc_m + 1) % 16;
    @(negedge clock);
    cmd_valid = cmd_go;
    cmd_count = CNT_W'(go_count);
    cmd_gap   = 16'(go_gap);
    if (ap_start && !k_pending) begin
      k_pending = 1;
      k_start = cyc_n;
      start_cyc.push_back(cyc_n);
      outstanding++;
      if (outstanding > max_out) max_out = outstanding;
    end
    ap_ready  = ap_start && k_pending && ((cyc_n - k_start) >= k_rd);
    ap_done   = k_spur || ((k_due_q.size() != 0) && (k_due_q[0] <= cyc_n));
    res_ready = !((cyc_n >= rr_from) && (cyc_n <= rr_to));
    #1;
    if (cmd_valid && cmd_ready) begin
      cmd_go = 0;
      cmd_acc_cyc = cyc_n;
    end
    if (ap_start) start_hi_cnt++;
    if (!ap_continue) cont_lo_cnt++;
    if (done_pulse) begin
      n_pulse++;
      pulse_cyc = cyc_n;
    end
    if (res_valid && res_ready) begin
      n_res++;
      res_lat.push_back(int'(res_latency));
      chk("res_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("res_index", 32'(res_index), 32'(e[LAT_W +: CNT_W]));
        chk("res_latency", 32'(res_latency), 32'(e[LAT_W-1:0]));
      end
    end
    if (ap_done && ap_continue && !k_spur && (k_start_q.size() != 0)) begin
      s = k_start_q.pop_front();
      void'(k_due_q.pop_front());
      outstanding--;
      last_done_cyc = cyc_n;
      exp_q.push_back({CNT_W'(exp_idx), LAT_W'(cyc_n - s)});
      exp_idx++;
    end
    if (ap_start && ap_ready) begin
      k_pending = 0;
      k_start_q.push_back(k_start);
      k_due_q.push_back(k_start + k_dd);
    end
    cyc_n++;
  endtask

  // driver: issue one command and run it to completion
  task automatic run_cmd(input int count, input int gap, input int rd, input int dd, input string tag);
    k_rd = rd;
    k_dd = dd;
    clear_stats();
    go_count = count;
    go_gap = gap;
    cmd_go = 1;
    for (int i = 0; i < 300 && n_pulse == 0; i++) step();
    cmd_go = 0;
    chk({tag, "_pulse_seen"}, 32'(n_pulse), 1);
    if (count == 0) begin
      chk({tag, "_no_start"}, 32'(start_hi_cnt), 0);
      chk({tag, "_pulse_cyc"}, 32'(pulse_cyc), 32'(cmd_acc_cyc + 1));
    end else begin
      chk({tag, "_first_start"}, 32'(sc(0)), 32'(cmd_acc_cyc + 1));
      chk({tag, "_pulse_cyc"}, 32'(pulse_cyc), 32'(last_done_cyc + 1));
    end
    step();
    chk({tag, "_idle_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_busy_off"}, 32'(busy), 0);
    chk({tag, "_n_pulse"}, 32'(n_pulse), 1);
    chk({tag, "_n_res"}, 32'(n_res), 32'(count));
    chk({tag, "_n_start"}, 32'(start_cyc.size()), 32'(count));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_ap_start"}, 32'(ap_start), 0);
    chk({tag, "_ap_continue"}, 32'(ap_continue), 1);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_latency"}, 32'(res_latency), 0);
    chk({tag, "_res_index"}, 32'(res_index), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done_pulse"}, 32'(done_pulse), 0);
    chk({tag, "_err"}, 32'(err_spurious), 0);
  endtask

  initial begin
    clear_stats();
    kernel_reset();
    reset = 1'b1;
    repeat (3) step();
    chk_reset_values("rst");
    reset = 1'b0;

    // single invocation: ready 1 cycle after start, done 5 after start
    run_cmd(1, 0, 1, 5, "single");
    chk("single_lat", 32'(rl(0)), 5);
    chk("single_err", 32'(err_spurious), 0);

    // back-to-back pipelined kernel, stalls at DEPTH outstanding
    run_cmd(8, 0, 0, 10, "b2b");
    chk("b2b_max_out", 32'(max_out), 4);
    chk("b2b_start3", 32'(sc(3) - sc(0)), 3);
    chk("b2b_start4", 32'(sc(4) - sc(0)), 11);
    chk("b2b_start7", 32'(sc(7) - sc(0)), 14);
    chk("b2b_hi_cycles", 32'(start_hi_cnt), 8);
    for (int i = 0; i < 8; i++) chk("b2b_lat", 32'(rl(i)), 10);

    // gap insertion
    run_cmd(3, 2, 0, 4, "gap");
    chk("gap_d1", 32'(sc(1) - sc(0)), 3);
    chk("gap_d2", 32'(sc(2) - sc(1)), 3);
    chk("gap_hi_cycles", 32'(start_hi_cnt), 3);
    for (int i = 0; i < 3; i++) chk("gap_lat", 32'(rl(i)), 4);

    // chain backpressure: res_ready low for 6 cycles from start+3
    rr_from = cyc_n + 4;
    rr_to   = cyc_n + 9;
    run_cmd(3, 0, 0, 3, "chain");
    rr_from = -1;
    rr_to   = -2;
    chk("chain_cont_lo", 32'(cont_lo_cnt), 5);
    chk("chain_lat0", 32'(rl(0)), 3);
    chk("chain_lat1", 32'(rl(1)), 8);
    chk("chain_lat2", 32'(rl(2)), 8);

    // zero count
    run_cmd(0, 0, 0, 1, "zero");

    // latency across a counter wrap: accepted at cyc 11, start at 12, done at 5
    for (int i = 0; i < 20 && cyc_m != 10; i++) step();
    run_cmd(1, 0, 0, 9, "wrap");
    chk("wrap_lat", 32'(rl(0)), 9);

    // spurious done in IDLE
    k_spur = 1;
    step();
    k_spur = 0;
    step();
    chk("spur_err", 32'(err_spurious), 1);
    chk("spur_no_res", 32'(res_valid), 0);
    repeat (4) step();
    chk("spur_sticky", 32'(err_spurious), 1);
    run_cmd(0, 0, 0, 1, "zero2");
    chk("spur_sticky_cmd", 32'(err_spurious), 1);

    // reset during DRAIN with 2 outstanding
    clear_stats();
    k_rd = 0;
    k_dd = 30;
    go_count = 2;
    go_gap = 0;
    cmd_go = 1;
    for (int i = 0; i < 20 && start_cyc.size() < 2; i++) step();
    repeat (2) step();
    chk("mid_busy", 32'(busy), 1);
    chk("mid_start_low", 32'(ap_start), 0);
    chk("mid_outstanding", 32'(start_cyc.size()), 2);
    reset = 1'b1;
    kernel_reset();
    step();
    reset = 1'b0;
    chk_reset_values("mid_rst");
    run_cmd(1, 0, 1, 5, "post_rst");
    chk("post_rst_lat", 32'(rl(0)), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ap_ctrl_driver.md
# ap_ctrl_driver

Active initiator for the ap_ctrl_hs / ap_ctrl_chain block-level handshake. It launches a hardware kernel (for example, matprod or one of its pipeline sub-blocks) a commanded number of times by driving `ap_start` and `ap_continue`. It measures the start-to-done latency of every invocation and streams each measurement out. It sits in the simulation and bring-up harness on the opposite side of the handshake from the passive dataflow status monitors.

## Interface
- `CNT_W`, 32: width of the invocation count and of the index counters.
- `LAT_W`, 32: width of the free-running cycle counter and of the latency values.
- `DEPTH`, 4: maximum outstanding invocations (started but not yet done). Must be a power of 2, ≥1.

- `clock`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: driver idle and able to accept a command.
- `cmd_count`  in  CNT_W: number of invocations; 0 is legal.
- `cmd_gap`  in  16: idle cycles inserted after each `ap_ready` before the next `ap_start`.
- `ap_start`  out  1: kernel start request.
- `ap_ready`  in  1: kernel accepted the current start.
- `ap_done`  in  1: kernel finished an invocation; held while `ap_continue` is low (chain mode).
- `ap_continue`  out  1: result slot free; completes the done handshake.
- `res_valid`  out  1: latency result available.
- `res_ready`  in  1: downstream accepts the result.
- `res_latency`  out  LAT_W: cycles from first `ap_start` assertion to the done acceptance.
- `res_index`  out  CNT_W: invocation number, 0-based.
- `busy`  out  1: command in progress.
- `done_pulse`  out  1: one-cycle pulse when a command completes.
- `err_spurious`  out  1: sticky flag; set if `ap_done` is accepted with zero outstanding invocations.

## Operation
- **Cycle counter.** `cyc` (LAT_W bits) is free-running. It is cleared by reset and wraps modulo 2^LAT_W.
- **Timestamp FIFO.** DEPTH entries, each LAT_W bits.
  - Push: the `cyc` value on the cycle an invocation's `ap_start` first rises.
  - Pop: on done acceptance.
  - A push and a pop in the same cycle are both legal; the occupancy count is then unchanged.
- **State machine.** States: IDLE, START, GAP, DRAIN, FIN.
  - **IDLE.** `cmd_ready`=1. On `cmd_valid`, latch count and gap, and clear `issued`, `completed` and `res_index`.
    - If count==0, go to FIN.
    - Otherwise go to START.
  - **START.** `ap_start`=1 only when FIFO occupancy < DEPTH; otherwise `ap_start`=0 and the driver waits.
    - On `ap_start`&`ap_ready`: increment `issued`.
    - If `issued`==count, go to DRAIN.
    - Else if gap>0, go to GAP.
    - Else stay in START, keeping `ap_start` high (back-to-back launches).
  - **GAP.** `ap_start`=0. Count down gap cycles, then go to START.
  - **DRAIN.** `ap_start`=0. When `completed`==count, go to FIN.
  - **FIN.** `done_pulse`=1 for one cycle, then go to IDLE.
- **Done acceptance.** A done is accepted when `ap_done`&`ap_continue`.
  - `ap_continue` = !`res_valid` | `res_ready`, in every state.
  - On acceptance:
    - Load `res_latency` = `cyc` − FIFO head (modulo 2^LAT_W).
    - Load `res_index` = `completed`.
    - Set `res_valid`, pop the FIFO and increment `completed`.
  - `res_valid` clears on `res_ready` unless a new result loads in the same cycle.
- **Spurious done.** Acceptance with the FIFO empty sets `err_spurious`. In that case there is no pop, no result and no change to `completed`.
- **Busy.** `busy` = state ∉ {IDLE}.

## Timing
- **Reset values.** All outputs are 0 except `cmd_ready`=1 and `ap_continue`=1.
  - Reset also clears the FIFO, the counters and `err_spurious`.
  - Reset mid-operation drops `ap_start` on the next edge and discards outstanding timestamps. The kernel must be reset alongside the driver.
- **Command to first start.** Command accepted at edge T → `ap_start`=1 in cycle T+1. The timestamp pushed is `cyc`(T+1).
- **Back-to-back launches.** With gap=0 and `ap_ready` at cycle R, `ap_start` stays 1 at R+1 (a new invocation).
- **Gapped launches.** With gap=g, `ap_start`=0 in cycles R+1..R+g and is 1 at R+g+1.
- **Result latency.** Done accepted in cycle D → `res_valid`=1 in cycle D+1.
- **Command completion.** The last done accepted in cycle D → `done_pulse` in cycle D+1 (FIN). IDLE and `cmd_ready`=1 follow at D+2.
- **Zero count.** count=0 accepted at T → `done_pulse` at T+1 with no `ap_start`.
- **Pure ap_ctrl_hs kernels.** `ap_done` is a single-cycle pulse; if the result slot is full, the driver does not complete the done handshake and that completion is lost. The bench must keep `res_ready`=1 for such kernels.

## Test plan
- **Single invocation.** count=1, gap=0; kernel `ap_ready` 1 cycle after start, `ap_done` 5 cycles after start → one result with latency=5, index=0, `done_pulse` once, `err_spurious`=0.
- **Back-to-back pipelined kernel.** count=8, gap=0, DEPTH=4; `ap_ready` immediately, done 10 cycles after each start → `ap_start` continuously high until 4 are outstanding, then stalls. Eight results, indices 0..7, each latency=10.
- **Gap insertion.** count=3, gap=2 → `ap_start` low for exactly 2 cycles after each `ap_ready`. Consecutive start edges are 3 cycles apart.
- **Chain backpressure.** `res_ready`=0 for 6 cycles while the kernel holds `ap_done` → `ap_continue` stays 0 until the slot frees; latencies include the stall; no results are lost.
- **Edge cases.**
  - count=0 → `done_pulse` 1 cycle after acceptance, no `ap_start`.
  - Spurious `ap_done` in IDLE → `err_spurious`=1, sticky until reset.
  - Latency across a `cyc` wrap (LAT_W=4) → latency still correct modulo 16.
- **Reset mid-run.** Assert `reset` during DRAIN with 2 outstanding → next cycle all outputs at reset values, FIFO empty. A new count=1 command then completes normally.
